regfile_scan_reader: RTL and testbench

- Read-side sequencer for the 4x16 register file.
- On a start pulse it walks `rs` through r0..r3 and samples the combinational read port `b`.
- Each sampled word goes out on a valid/ready stream, tagged with its register index, toward the video display datapath (status/debug overlay).
- Owns `rs` for the duration of a scan; the write side (`rd`/`result`) is untouched.

---
 rtl/vdp_pkg.sv | 17 +
 rtl/regfile_scan_reader_if.sv | 27 ++
 rtl/regfile_scan_reader.sv | 125 ++++++++++++
 tb/tb_regfile_scan_reader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared definitions for the video display datapath: register-file geometry
// and the register-file scan reader's state encoding.
package vdp_pkg;

    localparam int REG_ADDR_W = 2;
    localparam int REG_DATA_W = 16;
    localparam int NUM_REGS   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SAMPLE,
        ST_PRESENT,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/regfile_scan_reader_if.sv
// Valid/ready stream carrying one sampled register word plus its index.
interface regfile_scan_reader_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_idx,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/regfile_scan_reader.sv
// Walks the register-file read select over r0..NUM_REGS-1 and streams each
// sampled word out, tagged with its index; all outputs are registered.
module regfile_scan_reader #(
    parameter int NUM_REGS   = vdp_pkg::NUM_REGS,
    parameter int ADDR_W     = vdp_pkg::REG_ADDR_W,
    parameter int DATA_W     = vdp_pkg::REG_DATA_W,
    parameter int CONTINUOUS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_W-1:0]     rs,
    input  logic [DATA_W-1:0]     b,
    regfile_scan_reader_if.master strm,
    output logic                  busy,
    output logic                  done
);
    import vdp_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    scan_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic [ADDR_W-1:0] rs_reg, rs_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [ADDR_W-1:0] oidx_reg, oidx_next;
    logic              last_reg, last_next;
    logic              valid_reg, valid_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            rs_reg    <= '0;
            data_reg  <= '0;
            oidx_reg  <= '0;
            last_reg  <= 1'b0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            rs_reg    <= rs_next;
            data_reg  <= data_next;
            oidx_reg  <= oidx_next;
            last_reg  <= last_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        rs_next    = rs_reg;
        data_next  = data_reg;
        oidx_next  = oidx_reg;
        last_next  = last_reg;
        valid_next = valid_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    rs_next    = '0;
                    idx_next   = '0;
                    state_next = ST_SETUP;
                end
            end
            // rs has been stable for a full cycle here, so b has settled
            ST_SETUP: state_next = ST_SAMPLE;
            ST_SAMPLE: begin
                data_next  = b;
                oidx_next  = idx_reg;
                last_next  = (idx_reg == LAST_IDX);
                valid_next = 1'b1;
                state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (valid_reg && strm.out_ready) begin
                    valid_next = 1'b0;
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        rs_next    = idx_reg + 1'b1;
                        state_next = ST_SETUP;
                    end
                end
            end
            ST_DONE: begin
                if (CONTINUOUS != 0) begin
                    rs_next    = '0;
                    idx_next   = '0;
                    state_next = ST_SETUP;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A handshake coinciding with abort has already been accepted above
        if (abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
            valid_next = 1'b0;
        end

        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
    end

    assign rs             = rs_reg;
    assign strm.out_data  = data_reg;
    assign strm.out_idx   = oidx_reg;
    assign strm.out_last  = last_reg;
    assign strm.out_valid = valid_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Directed and randomized bench for regfile_scan_reader: one single-pass
// instance and one continuous instance, each with its own register-file model.
module tb_regfile_scan_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, abort0, start1, abort1;
    logic [1:0]  rs0, rs1;
    logic [15:0] b0, b1;
    logic        busy0, done0, busy1, done1;
    logic [15:0] regs0 [4];
    logic [15:0] regs1 [4];

    int errors = 0;
    int checks = 0;

    regfile_scan_reader_if #(.ADDR_W(2), .DATA_W(16)) s0 ();
    regfile_scan_reader_if #(.ADDR_W(2), .DATA_W(16)) s1 ();

    assign b0 = regs0[rs0];
    assign b1 = regs1[rs1];

    regfile_scan_reader #(.NUM_REGS(4), .ADDR_W(2), .DATA_W(16), .CONTINUOUS(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .rs(rs0), .b(b0),
        .strm(s0), .busy(busy0), .done(done0)
    );

    regfile_scan_reader #(.NUM_REGS(4), .ADDR_W(2), .DATA_W(16), .CONTINUOUS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .rs(rs1), .b(b1),
        .strm(s1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One full pass on dut0 scored against the words the register file holds
    // when each is sampled. Optional consumer stall on one index, random ready,
    // and a mid-scan write of r2 plus a start pulse while busy.
    task automatic scan(input int stall_idx, input int stall_len, input bit rnd_ready,
                        input bit poke, output int got, output int dones);
        logic [15:0] exp [4];
        int stalled;
        bit poked;
        for (int i = 0; i < 4; i++) exp[i] = regs0[i];
        got = 0; dones = 0; stalled = 0; poked = 1'b0;
        s0.out_ready = 1'b1;
        start0 = 1'b1;
        for (int n = 0; n < 300 && dones == 0; n++) begin
            cyc();
            start0 = 1'b0;
            if (done0) dones++;
            if (s0.out_valid) begin
                if (poke && !poked && s0.out_idx == 2'd1) begin
                    regs0[2] = 16'h1234;
                    exp[2]   = 16'h1234;
                    start0   = 1'b1;
                    poked    = 1'b1;
                end
                if (int'(s0.out_idx) == stall_idx && stalled < stall_len) begin
                    s0.out_ready = 1'b0;
                    check("hold_data", 32'(s0.out_data), 32'(exp[stall_idx]));
                    check("hold_rs", 32'(rs0), 32'(stall_idx));
                    stalled++;
                end else begin
                    s0.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (s0.out_ready) begin
                    check("word_data", 32'(s0.out_data), 32'(exp[got & 3]));
                    check("word_idx", 32'(s0.out_idx), 32'(got));
                    check("word_last", 32'(s0.out_last), 32'(got == 3));
                    got++;
                end
            end
        end
        start0 = 1'b0;
        s0.out_ready = 1'b1;
        check("scan_done_seen", 32'(dones), 32'd1);
        check("scan_words", 32'(got), 32'd4);
        if (stall_len > 0) check("stall_cycles", 32'(stalled), 32'(stall_len));
        cyc();
        check("scan_idle", 32'(busy0), 32'd0);
    endtask

    initial begin
        int got, dones, pos;
        bit found;

        rst = 1'b1; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        s0.out_ready = 1'b1; s1.out_ready = 1'b1;
        regs0[0] = 16'hAAAA; regs0[1] = 16'hBBBB; regs0[2] = 16'hCCCC; regs0[3] = 16'hDDDD;
        for (int i = 0; i < 4; i++) regs1[i] = regs0[i];

        // Reset state
        cyc(); cyc(); cyc();
        check("rst_rs", 32'(rs0), 32'd0);
        check("rst_data", 32'(s0.out_data), 32'd0);
        check("rst_idx", 32'(s0.out_idx), 32'd0);
        check("rst_last", 32'(s0.out_last), 32'd0);
        check("rst_valid", 32'(s0.out_valid), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        rst = 1'b0;
        cyc();

        // Basic pass, ready high: word every 3 cycles, done on cycle 13
        start0 = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            start0 = 1'b0;
            check("t1_valid", 32'(s0.out_valid), 32'(k % 3 == 0 && k <= 12));
            if (k % 3 == 0 && k <= 12) begin
                check("t1_data", 32'(s0.out_data), 32'(regs0[k/3 - 1]));
                check("t1_idx", 32'(s0.out_idx), 32'(k/3 - 1));
                check("t1_last", 32'(s0.out_last), 32'(k == 12));
            end
            if (k <= 13) check("t1_rs", 32'(rs0), 32'((k <= 12) ? (k - 1) / 3 : 3));
            check("t1_done", 32'(done0), 32'(k == 13));
            check("t1_busy", 32'(busy0), 32'(k <= 13));
        end

        // Consumer stalls 5 cycles on BBBB
        scan(1, 5, 1'b0, 1'b0, got, dones);

        // Abort while presenting idx 2
        found = 1'b0;
        start0 = 1'b1;
        for (int n = 0; n < 40 && !found; n++) begin
            cyc();
            start0 = 1'b0;
            if (s0.out_valid && s0.out_idx == 2'd2) found = 1'b1;
        end
        check("abort_reach", 32'(found), 32'd1);
        s0.out_ready = 1'b0;
        abort0 = 1'b1;
        cyc();
        abort0 = 1'b0;
        s0.out_ready = 1'b1;
        check("abort_valid", 32'(s0.out_valid), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        dones = 0;
        for (int n = 0; n < 15; n++) begin
            cyc();
            if (done0) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        scan(-1, 0, 1'b0, 1'b0, got, dones);

        // Synchronous reset mid-scan with start in the same cycle
        found = 1'b0;
        start0 = 1'b1;
        for (int n = 0; n < 40 && !found; n++) begin
            cyc();
            start0 = 1'b0;
            if (s0.out_valid && s0.out_idx == 2'd1) found = 1'b1;
        end
        check("mrst_reach", 32'(found), 32'd1);
        s0.out_ready = 1'b0;
        rst = 1'b1;
        start0 = 1'b1;
        cyc();
        rst = 1'b0;
        start0 = 1'b0;
        s0.out_ready = 1'b1;
        check("mrst_valid", 32'(s0.out_valid), 32'd0);
        check("mrst_data", 32'(s0.out_data), 32'd0);
        check("mrst_idx", 32'(s0.out_idx), 32'd0);
        check("mrst_rs", 32'(rs0), 32'd0);
        check("mrst_busy", 32'(busy0), 32'd0);
        for (int n = 0; n < 3; n++) begin
            cyc();
            check("mrst_stay_idle", 32'(busy0), 32'd0);
        end

        // Write r2 while idx 1 is presented, plus start pulse while busy
        scan(-1, 0, 1'b0, 1'b1, got, dones);
        for (int n = 0; n < 4; n++) begin
            cyc();
            check("no_restart", 32'(busy0), 32'd0);
        end

        // Randomized contents and consumer back-pressure
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 4; i++) regs0[i] = 16'($urandom);
            scan(-1, 0, 1'b1, 1'b0, got, dones);
        end

        // Continuous instance: three back-to-back 13-cycle passes
        start1 = 1'b1;
        for (int k = 1; k <= 39; k++) begin
            cyc();
            start1 = 1'b0;
            pos = (k - 1) % 13 + 1;
            check("c_valid", 32'(s1.out_valid), 32'(pos % 3 == 0 && pos <= 12));
            if (pos % 3 == 0 && pos <= 12)
                check("c_data", 32'(s1.out_data), 32'(regs1[pos/3 - 1]));
            check("c_rs", 32'(rs1), 32'((pos <= 12) ? (pos - 1) / 3 : 3));
            check("c_done", 32'(done1), 32'(pos == 13));
        end
        abort1 = 1'b1;
        cyc();
        abort1 = 1'b0;
        check("c_abort_busy", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
